// File: rtl/cpu0_pkg.sv
// Shared encodings for the CPU0 control sequencer: opcodes, FSM states,
// ALU operations and datapath mux selects.
package cpu0_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LD,
    CL_ST,
    CL_JMP,
    CL_ILLEGAL
  } op_class_e;

  localparam logic [7:0] OP_LD  = 8'h00;
  localparam logic [7:0] OP_ST  = 8'h01;
  localparam logic [7:0] OP_ADD = 8'h13;
  localparam logic [7:0] OP_SUB = 8'h14;
  localparam logic [7:0] OP_MUL = 8'h15;
  localparam logic [7:0] OP_DIV = 8'h16;
  localparam logic [7:0] OP_AND = 8'h18;
  localparam logic [7:0] OP_OR  = 8'h19;
  localparam logic [7:0] OP_XOR = 8'h1A;
  localparam logic [7:0] OP_SHL = 8'h1E;
  localparam logic [7:0] OP_SHR = 8'h1F;
  localparam logic [7:0] OP_JMP = 8'h26;

  localparam logic [3:0] ALU_PASS = 4'h2;
  localparam logic [3:0] ALU_ADD  = 4'h3;
  localparam logic [3:0] ALU_SHR  = 4'hF;

  localparam logic       MAR_SEL_PC   = 1'b0;
  localparam logic       MAR_SEL_MAR  = 1'b1;
  localparam logic       PC_SRC_PLUS4 = 1'b0;
  localparam logic       PC_SRC_ALU   = 1'b1;
  localparam logic       A_SEL_RB     = 1'b0;
  localparam logic       A_SEL_PC     = 1'b1;
  localparam logic [1:0] B_SEL_RC     = 2'd0;
  localparam logic [1:0] B_SEL_CX16   = 2'd1;
  localparam logic [1:0] B_SEL_CX24   = 2'd2;
  localparam logic       WD_SEL_ALU   = 1'b0;
  localparam logic       WD_SEL_MDR   = 1'b1;

endpackage

// File: rtl/cpu0_seq_if.sv
// Memory request/ready handshake between the CPU0 sequencer and memory.
interface cpu0_seq_if;
  logic mem_en;
  logic mem_rw;
  logic mem_ready;

  modport master (output mem_en, output mem_rw, input mem_ready);
  modport slave  (input mem_en, input mem_rw, output mem_ready);
endinterface

// File: rtl/cpu0_opclass.sv
// Opcode classifier: maps ir[31:24] to an instruction class and ALU opcode.
module cpu0_opclass
  import cpu0_pkg::*;
(
  input  logic [7:0] op,
  output op_class_e  op_class,
  output logic [3:0] alu_op
);

  always_comb begin
    op_class = CL_ILLEGAL;
    alu_op   = ALU_ADD;
    case (op)
      OP_LD:  op_class = CL_LD;
      OP_ST:  op_class = CL_ST;
      OP_JMP: op_class = CL_JMP;
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND,
      OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
        op_class = CL_ALU;
        alu_op   = op[3:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu0_seq.sv
// CPU0 multi-cycle control sequencer (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Optional memory wait timeout: define CPU0_SEQ_TIMEOUT_EN.
module cpu0_seq
  import cpu0_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ir,
  cpu0_seq_if.master  mem,
  output logic        mar_sel,
  output logic        mar_w,
  output logic        ir_w,
  output logic        mdr_w,
  output logic        pc_w,
  output logic        pc_src,
  output logic [3:0]  alu_op,
  output logic        alu_a_sel,
  output logic [1:0]  alu_b_sel,
  output logic        reg_w,
  output logic        wd_sel,
  output logic [2:0]  state,
  output logic        halted,
  output logic        bus_err
);

  state_e     state_q, state_d;
  op_class_e  op_class;
  logic [3:0] class_alu_op;
  logic       tmo;
  logic       mem_en_c, mem_rw_c;
  logic       unused_ir;

  assign unused_ir = ^ir[23:0];

  cpu0_opclass u_opclass (
    .op       (ir[31:24]),
    .op_class (op_class),
    .alu_op   (class_alu_op)
  );

`ifdef CPU0_SEQ_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic          in_access;

  assign in_access = (state_q == FETCH) || (state_q == MEM);
  assign tmo       = in_access && (wait_cnt == CW'(TIMEOUT));

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      if (tmo) bus_err <= 1'b1;
      if (in_access && !mem.mem_ready && !tmo) wait_cnt <= wait_cnt + 1'b1;
      else                                     wait_cnt <= '0;
    end
  end
`else
  localparam int unsigned unused_timeout = TIMEOUT;
  assign tmo     = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      halted  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == HALT) halted <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_en_c  = 1'b0;
    mem_rw_c  = 1'b0;
    mar_sel   = MAR_SEL_PC;
    mar_w     = 1'b0;
    ir_w      = 1'b0;
    mdr_w     = 1'b0;
    pc_w      = 1'b0;
    pc_src    = PC_SRC_PLUS4;
    alu_op    = '0;
    alu_a_sel = A_SEL_RB;
    alu_b_sel = B_SEL_RC;
    reg_w     = 1'b0;
    wd_sel    = WD_SEL_ALU;
    case (state_q)
      FETCH: begin
        if (tmo) state_d = HALT;
        else begin
          mem_en_c = 1'b1;
          mem_rw_c = 1'b1;
          mar_sel  = MAR_SEL_PC;
          if (mem.mem_ready) begin
            ir_w    = 1'b1;
            pc_w    = 1'b1;
            pc_src  = PC_SRC_PLUS4;
            state_d = DECODE;
          end
        end
      end
      DECODE: state_d = (op_class == CL_ILLEGAL) ? HALT : EXEC;
      EXEC: begin
        alu_op = class_alu_op;
        case (op_class)
          CL_ALU: begin
            reg_w   = 1'b1;
            wd_sel  = WD_SEL_ALU;
            state_d = FETCH;
          end
          CL_JMP: begin
            alu_a_sel = A_SEL_PC;
            alu_b_sel = B_SEL_CX24;
            pc_w      = 1'b1;
            pc_src    = PC_SRC_ALU;
            state_d   = FETCH;
          end
          CL_LD, CL_ST: begin
            alu_b_sel = B_SEL_CX16;
            mar_w     = 1'b1;
            state_d   = MEM;
          end
          default: state_d = HALT;
        endcase
      end
      MEM: begin
        if (tmo) state_d = HALT;
        else begin
          mem_en_c = 1'b1;
          mar_sel  = MAR_SEL_MAR;
          mem_rw_c = (op_class == CL_LD);
          if (mem.mem_ready) begin
            if (op_class == CL_LD) begin
              mdr_w   = 1'b1;
              state_d = WB;
            end else begin
              state_d = FETCH;
            end
          end
        end
      end
      WB: begin
        reg_w   = 1'b1;
        wd_sel  = WD_SEL_MDR;
        state_d = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
    // Reset forces all strobes/selects low, abandoning any access in flight.
    if (reset) begin
      mem_en_c  = 1'b0;
      mem_rw_c  = 1'b0;
      mar_sel   = 1'b0;
      mar_w     = 1'b0;
      ir_w      = 1'b0;
      mdr_w     = 1'b0;
      pc_w      = 1'b0;
      pc_src    = 1'b0;
      alu_op    = '0;
      alu_a_sel = 1'b0;
      alu_b_sel = '0;
      reg_w     = 1'b0;
      wd_sel    = 1'b0;
    end
  end

  assign mem.mem_en = mem_en_c;
  assign mem.mem_rw = mem_rw_c;
  assign state      = state_q;

endmodule

// File: doc/cpu0_seq.md
Name: cpu0_seq

Overview:
Multi-cycle control sequencer for the CPU0 datapath: register bank (R15 = PC), ALU, IR/MAR/MDR registers and a shared single-port memory. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and waits on a memory ready handshake. It drives every datapath strobe and mux select. It replaces the fixed "always fetch, PC+4" wiring in the cpu module.

Parameters:
TIMEOUT, 16, max wait cycles for mem_ready before a bus error (used only with the optional feature)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
ir  in  32  instruction register contents; op=ir[31:24]
mem_ready  in  1  memory completed the current access this cycle
mem_en  out  1  memory access request
mem_rw  out  1  1=read, 0=write
mar_sel  out  1  memory address: 0=PC, 1=MAR
mar_w  out  1  load MAR from ALU out
ir_w  out  1  load IR from memory data bus
mdr_w  out  1  load MDR from memory data bus
pc_w  out  1  write R15
pc_src  out  1  0=PC+4, 1=ALU out
alu_op  out  4  ALU opcode (PASS=2, ADD=3 … SHR=F)
alu_a_sel  out  1  0=R[rb], 1=PC
alu_b_sel  out  2  0=R[rc], 1=sext(cx16), 2=sext(cx24)
reg_w  out  1  write R[ra]
wd_sel  out  1  register write data: 0=ALU out, 1=MDR
state  out  3  current state (debug)
halted  out  1  sticky halt flag
bus_err  out  1  sticky timeout flag (0 when feature absent)

Behaviour:
- Reset (synchronous): state<=FETCH, halted<=0, bus_err<=0, wait counter<=0. While reset=1, every strobe and select output is 0. Reset overrides any state, including a pending memory access, which is abandoned. The first fetch request appears in the first cycle after reset deasserts.
- Outputs are decoded from the state register and ir. Outputs gated by mem_ready are Mealy: ir_w, pc_w in FETCH, and mdr_w in MEM.
- Supported opcodes:
  - LD 00: R[ra]=M[R[rb]+cx16]
  - ST 01: M[R[rb]+cx16]=R[ra]
  - ALU ops 13,14,15,16,18,19,1A,1E,1F: alu_op=op[3:0], R[ra]=R[rb] op R[rc]
  - JMP 26: PC=PC+4+sext(cx24)
  - Any other opcode is illegal.
- FETCH:
  - mem_en=1, mem_rw=1, mar_sel=0 are held until mem_ready.
  - In the ready cycle: ir_w=1, pc_w=1, pc_src=0, then go to DECODE.
  - Without ready, stay in FETCH.
- DECODE: one cycle, no strobes. Legal opcode -> EXEC. Illegal opcode -> HALT.
- EXEC:
  - ALU ops: alu_a_sel=0, alu_b_sel=0, reg_w=1, wd_sel=0, then FETCH.
  - JMP: alu_a_sel=1, alu_b_sel=2, alu_op=ADD, pc_w=1, pc_src=1, then FETCH.
  - LD/ST: alu_a_sel=0, alu_b_sel=1, alu_op=ADD, mar_w=1, then MEM.
- MEM:
  - mem_en=1, mar_sel=1, mem_rw=1 for LD and 0 for ST, held until mem_ready.
  - LD in the ready cycle: mdr_w=1, then WB.
  - ST in the ready cycle: go to FETCH.
- WB: reg_w=1, wd_sel=1, then FETCH.
- HALT: all strobes 0, halted=1. Only reset leaves HALT.
- Zero-wait CPI: ALU 3, JMP 3, ST 4, LD 5.
- mem_ready outside FETCH/MEM is ignored.
- mem_en never toggles mid-access: it stays high continuously until the ready cycle.
- ra=15 on an ALU op or LD is legal. It writes the PC, and the next FETCH uses the written value.
- Required state encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.

Optional Feature:
CPU0_SEQ_TIMEOUT_EN
- Defined:
  - A counter runs while in FETCH or MEM with mem_ready=0. It clears on ready or on a state change.
  - When it reaches TIMEOUT, bus_err<=1, the request is dropped (mem_en=0), and state goes to HALT.
- Undefined: there is no counter, waits are unbounded, and bus_err is tied to 0.

Decomposition:
- Package cpu0_pkg holds:
  - opcode constants (LD, ST, ADD…SHR, JMP)
  - state encoding
  - ALU op constants
  - select encodings for mar_sel, pc_src, alu_b_sel and wd_sel
- One sub-module, cpu0_opclass: combinational op -> {class: ALU/LD/ST/JMP/ILLEGAL, alu_op}. The sequencer instantiates it once.

Test Plan:
- Zero-wait ADD (ir=13221000), mem_ready always 1. Expect:
  - states FETCH, DECODE, EXEC, FETCH
  - ir_w and pc_w in cycle 1
  - reg_w=1, alu_op=3 in cycle 3
- LD (ir=001F0018) with mem_ready delayed 2 cycles in FETCH and in MEM:
  - mem_en held high for 3 cycles in each
  - mar_w in EXEC
  - mdr_w only in the ready cycle
  - WB has reg_w=1, wd_sel=1
  - total 9 cycles
- ST (ir=012F0020): MEM has mem_rw=0, mar_sel=1; no reg_w at any point; returns to FETCH after 4 cycles.
- JMP (ir=26FFFFF4): EXEC has pc_w=1, pc_src=1, alu_a_sel=1, alu_b_sel=2, alu_op=3.
- Illegal op (ir=FF000000): DECODE goes to HALT; halted=1; strobes stay 0 for 10 cycles; reset for 1 cycle returns to FETCH with halted=0.
- Reset asserted in MEM mid-wait: next cycle all outputs 0. With CPU0_SEQ_TIMEOUT_EN and TIMEOUT=4, mem_ready stuck at 0 in FETCH gives bus_err=1 and HALT after 4 wait cycles.
